// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 20-bit, 32-entry register datapath:
// owns PC, IR and the retire counter, and handshakes with the execution paths.
module instr_sequencer #(
  parameter int         PC_W     = 5,
  parameter int         CNT_W    = 16,
  parameter logic [4:0] OP_NOP   = 5'd0,
  parameter logic [4:0] OP_JMP   = 5'd30,
  parameter logic [4:0] OP_HALT  = 5'd31,
  parameter int         MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [19:0]      imem_data,
  input  logic             op_done,
  output logic [PC_W-1:0]  pc,
  output logic [19:0]      ir,
  output logic             op_start,
  output logic             reg_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int                WAIT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  RETIRED_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d, resume_s;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc_s, jmp_tgt_s;
  logic [19:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              op_start_q, op_start_d;
  logic              reg_we_q, reg_we_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              retire_s;
  logic [4:0]        opcode_s;

  assign opcode_s  = ir_q[4:0];
  assign jmp_tgt_s = PC_W'(ir_q[9:5]);
  assign pc_inc_s  = pc_q + PC_W'(1);
  // run is only consulted where the next fetch would begin
  assign resume_s  = run ? S_FETCH : S_IDLE;

  // Next-state, datapath-register and strobe decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_d     = wait_q;
    op_start_d = 1'b0;
    reg_we_d   = 1'b0;
    halted_d   = halted_q;
    fault_d    = fault_q;
    retire_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        ir_d    = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode_s == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          retire_s = 1'b1;
        end else if (opcode_s == OP_JMP) begin
          pc_d     = jmp_tgt_s;
          retire_s = 1'b1;
          state_d  = resume_s;
        end else if (opcode_s == OP_NOP) begin
          pc_d     = pc_inc_s;
          retire_s = 1'b1;
          state_d  = resume_s;
        end else begin
          state_d    = S_EXEC;
          wait_d     = '0;
          op_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (op_done) begin
          state_d  = S_WB;
          reg_we_d = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        pc_d     = pc_inc_s;
        retire_s = 1'b1;
        state_d  = resume_s;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire_s && (retired_q != RETIRED_MAX)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and output registers; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= 20'd0;
      wait_q     <= '0;
      retired_q  <= '0;
      op_start_q <= 1'b0;
      reg_we_q   <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      op_start_q <= op_start_d;
      reg_we_q   <= reg_we_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign op_start = op_start_q;
  assign reg_we   = reg_we_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level model predicts each
// retirement; a negedge monitor compares whenever the DUT finishes an instruction.
module tb_instr_sequencer;
  localparam int PC_W     = 5;
  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 16;
  localparam int DEPTH    = 1 << PC_W;
  localparam int RET_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             op_done = 1'b0;
  logic [19:0]      imem_data;
  logic [PC_W-1:0]  pc;
  logic [19:0]      ir;
  logic             op_start, reg_we, halted, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [19:0]      imem [DEPTH];

  assign imem_data = imem[pc];
  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_data(imem_data), .op_done(op_done),
    .pc(pc), .ir(ir), .op_start(op_start), .reg_we(reg_we), .halted(halted),
    .fault(fault), .state(state), .retired(retired)
  );

  typedef struct {
    int pc; int retired; int ir; int starts; int wes; int halted; int fault; int cycles;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   n_checks = 0, n_fail = 0;
  bit   mon_en = 1'b0;
  int   ev_count = 0;
  int   m_pc = 0, m_ret = 0;
  bit   m_halted = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none (t=%0t)", name, $time);
  endtask

  // Instruction-level reference: one entry per retirement or terminating fault
  task automatic model_gen(input int n, input int fixed_delay, output int n_eff);
    exp_t e;
    int   op, d;
    n_eff = 0;
    for (int i = 0; i < n; i++) begin
      if (m_halted) break;
      e.ir = int'(imem[m_pc]);
      op = e.ir % 32;
      e.starts = 0; e.wes = 0; e.fault = 0; e.cycles = 2;
      if (op == 31) begin
        m_halted = 1'b1;
        m_ret = (m_ret == RET_MAX) ? RET_MAX : m_ret + 1;
      end else if (op == 30) begin
        m_pc = ((e.ir >> 5) & 31) % DEPTH;
        m_ret = (m_ret == RET_MAX) ? RET_MAX : m_ret + 1;
      end else if (op == 0) begin
        m_pc = (m_pc + 1) % DEPTH;
        m_ret = (m_ret == RET_MAX) ? RET_MAX : m_ret + 1;
      end else begin
        d = (fixed_delay < 0) ? int'($urandom_range(0, 5)) : fixed_delay;
        delay_q.push_back(d);
        e.starts = 1;
        if (d >= MAX_WAIT) begin
          m_halted = 1'b1;
          e.fault = 1;
          e.cycles = 2 + MAX_WAIT;
        end else begin
          e.wes = 1;
          e.cycles = 4 + d;
          m_pc = (m_pc + 1) % DEPTH;
          m_ret = (m_ret == RET_MAX) ? RET_MAX : m_ret + 1;
        end
      end
      e.halted = m_halted ? 1 : 0;
      e.pc = m_pc;
      e.retired = m_ret;
      exp_q.push_back(e);
      n_eff++;
    end
  endtask

  // Execution-path responder: op_done on the (delay+1)-th EXEC cycle, noise elsewhere
  int cur_delay = 0, ex_cnt = 0;
  always @(negedge clk) begin
    if (state == 3'd3) begin
      if (op_start) begin
        if (delay_q.size() != 0) cur_delay = delay_q.pop_front();
        else begin fail_now("delay_underflow"); cur_delay = 0; end
        ex_cnt = 0;
      end
      op_done = (ex_cnt == cur_delay);
      ex_cnt++;
    end else begin
      op_done = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: detects instruction completion from the state output and scores it
  logic [2:0] prev_state = 3'd0;
  int         cyc = 0, n_st = 0, n_we = 0;
  exp_t       me;
  bit         ev;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_state = 3'd0; cyc = 0; n_st = 0; n_we = 0;
    end else begin
      cyc++;
      if (op_start) n_st++;
      if (reg_we) n_we++;
      check("start_we_overlap", int'(op_start & reg_we), 0);
      check("we_outside_wb", int'(reg_we && state != 3'd4), 0);
      check("start_outside_exec", int'(op_start && state != 3'd3), 0);
      ev = (prev_state == 3'd2 && state != 3'd3) || (prev_state == 3'd4) ||
           (prev_state == 3'd3 && state == 3'd5);
      if (ev) begin
        if (exp_q.size() == 0) fail_now("unexpected_completion");
        else begin
          me = exp_q.pop_front();
          check("pc", int'(pc), me.pc);
          check("retired", int'(retired), me.retired);
          check("ir", int'(ir), me.ir);
          check("op_start_pulses", n_st, me.starts);
          check("reg_we_pulses", n_we, me.wes);
          check("halted", int'(halted), me.halted);
          check("fault", int'(fault), me.fault);
          check("instr_cycles", cyc, me.cycles);
        end
        ev_count++;
        n_st = 0;
        n_we = 0;
      end
      if (state == 3'd1) cyc = 0;
      prev_state = state;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    run = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    delay_q.delete();
    ev_count = 0;
    m_pc = 0; m_ret = 0; m_halted = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || !(state == 3'd0 || state == 3'd5)) && t < 2000) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 2000) begin
      fail_now("done_timeout");
      exp_q.delete();
      delay_q.delete();
    end
    check("park_state", int'(state), m_halted ? 5 : 0);
    check("delay_queue_drained", delay_q.size(), 0);
  endtask

  task automatic launch(input int n_eff);
    int base, t;
    base = ev_count;
    @(negedge clk);
    run = 1'b1;
    if (n_eff <= 1) begin
      @(posedge clk); #1 run = 1'b0;
    end else begin
      t = 0;
      while (ev_count < base + n_eff - 1 && t < 5000) begin @(negedge clk); #1; t++; end
      if (t >= 5000) fail_now("launch_timeout");
      run = 1'b0;
    end
    wait_done();
  endtask

  task automatic run_batch(input int n, input int fixed_delay);
    int n_eff;
    model_gen(n, fixed_delay, n_eff);
    launch(n_eff);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_eff, t;
    logic [19:0] w;
    for (int a = 0; a < DEPTH; a++) imem[a] = 20'd0;
    do_reset();

    check("rst_pc", int'(pc), 0);
    check("rst_ir", int'(ir), 0);
    check("rst_state", int'(state), 0);
    check("rst_op_start", int'(op_start), 0);
    check("rst_reg_we", int'(reg_we), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_retired", int'(retired), 0);

    // Basic 4-cycle instruction traced cycle by cycle, then a NOP
    imem[0] = 20'h00001;
    model_gen(2, 0, n_eff);
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      check("trace_state", int'(state), (c == 1 || c == 5) ? 1 : c);
      check("trace_op_start", int'(op_start), (c == 3) ? 1 : 0);
      check("trace_reg_we", int'(reg_we), (c == 4) ? 1 : 0);
    end
    check("trace_pc", int'(pc), 1);
    check("trace_retired", int'(retired), 1);
    run = 1'b0;
    wait_done();

    // Slow execute (3 EXEC cycles), then an execute timeout
    imem[2] = 20'h12345;
    imem[2][4:0] = 5'd5;
    run_batch(1, 2);
    imem[3] = 20'h00007;
    run_batch(1, 99);
    check("timeout_state", int'(state), 5);
    check("timeout_fault", int'(fault), 1);

    // JMP to 7, then a wrap from pc 31 to 0, then HALT opcode
    do_reset();
    imem[2] = {5'd0, 5'd0, 5'd7, OP_JMP_C()};
    imem[7] = 20'h00003;
    imem[8] = {5'd0, 5'd0, 5'd31, OP_JMP_C()};
    imem[31] = 20'h00004;
    imem[0] = 20'd0;
    imem[1] = 20'd0;
    run_batch(6, 1);
    check("wrap_pc", int'(pc), 0);
    imem[0] = 20'h0001F;
    run_batch(1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); run = ~run;
      @(posedge clk); #1;
      check("halt_sticky_state", int'(state), 5);
      check("halt_no_start", int'(op_start), 0);
      check("halt_no_we", int'(reg_we), 0);
    end
    run = 1'b0;

    // run dropped mid-EXEC at pc 4: writeback still completes, then resume at pc 5
    do_reset();
    for (int a = 0; a < 4; a++) imem[a] = 20'd0;
    imem[4] = 20'h00009;
    imem[5] = 20'h0000A;
    model_gen(5, 6, n_eff);
    @(negedge clk);
    run = 1'b1;
    t = 0;
    while (!(pc == 5'd4 && state == 3'd3) && t < 100) begin @(negedge clk); #1; t++; end
    if (t >= 100) fail_now("reach_exec_pc4");
    run = 1'b0;
    wait_done();
    check("run_drop_pc", int'(pc), 5);
    run_batch(1, 0);

    // Randomized programs
    for (int b = 0; b < 3; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = 20'($urandom);
        case ($urandom_range(0, 9))
          0, 1:    w[4:0] = 5'd0;
          2, 3:    w[4:0] = 5'd30;
          default: w[4:0] = 5'($urandom_range(1, 29));
        endcase
        imem[a] = w;
      end
      run_batch(30, -1);
    end

    // Asynchronous reset in the middle of an EXEC
    imem[m_pc] = 20'hABCD6;
    delay_q.push_back(10);
    @(negedge clk);
    run = 1'b1;
    t = 0;
    while (state != 3'd3 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) fail_now("reach_exec_for_reset");
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", int'(pc), 0);
    check("arst_ir", int'(ir), 0);
    check("arst_state", int'(state), 0);
    check("arst_op_start", int'(op_start), 0);
    check("arst_reg_we", int'(reg_we), 0);
    check("arst_halted", int'(halted), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_retired", int'(retired), 0);

    // Retire-counter saturation
    do_reset();
    for (int a = 0; a < DEPTH; a++) imem[a] = 20'd0;
    run_batch(RET_MAX + 5, 0);
    check("retired_saturated", int'(retired), RET_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [4:0] OP_JMP_C();
    return 5'd30;
  endfunction

endmodule
